// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_e  : controller state encoding (IDLE, RUN, DONE)
//   NIBBLE_W : width of the shared carry-lookahead slice
//   clog2    : width helper for the pass counter (never returns 0)
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
//   in_*  : operand request channel (valid/ready), A, B, carry-in, subtract
//   out_* : result channel (valid/ready), sum, carry-out, signed overflow
// master = requester/consumer side, slave = the adder sequencer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_cla_slice4.sv
// cla_slice4: combinational 4-bit carry-lookahead adder.
//   a, b : addend nibbles
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module cla_slice4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // All carries are flat sum-of-products of generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract that reuses one 4-bit
// carry-lookahead slice over WIDTH/4 cycles, least-significant nibble first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_add_ctrl_if (operand and result
//           valid/ready channels, sum, carry-out, signed overflow)
// An accepted operand pair yields out_valid NIB edges later; the result is
// held until the consumer takes it, then the block returns to IDLE.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = clog2(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_ovf_q, out_ovf_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    b_eff;
  logic [WIDTH-1:0]    sum_shifted;

  cla_slice4 u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign b_eff       = bus.in_sub ? ~bus.in_b : bus.in_b;
  // Each pass deposits its nibble at the top; after NIB passes the first
  // nibble has walked down to bit 0.
  assign sum_shifted = {slice_sum, sum_sh_q[WIDTH-1:NIBBLE_W]};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (!in_ready_q) begin
          // First edge out of reset only raises ready; nothing is accepted.
          in_ready_d = 1'b1;
        end else if (bus.in_valid) begin
          a_sh_d     = bus.in_a;
          b_sh_d     = b_eff;
          carry_d    = bus.in_sub ? 1'b1 : bus.in_cin;
          a_msb_d    = bus.in_a[WIDTH-1];
          b_msb_d    = b_eff[WIDTH-1];
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        a_sh_d   = {{NIBBLE_W{1'b0}}, a_sh_q[WIDTH-1:NIBBLE_W]};
        b_sh_d   = {{NIBBLE_W{1'b0}}, b_sh_q[WIDTH-1:NIBBLE_W]};
        sum_sh_d = sum_shifted;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_sum_d   = sum_shifted;
          out_cout_d  = slice_cout;
          out_ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[NIBBLE_W-1] != a_msb_q);
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16.
module tb_nibble_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  bit   scramble;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50; k++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    wait_ready();
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until out_valid, 0 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.in_a   = 16'($urandom);
        bus.in_b   = 16'($urandom);
        bus.in_cin = ~bus.in_cin;
        bus.in_sub = ~bus.in_sub;
      end
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] es,
                              input logic ec, input logic eo);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'd0, bus.out_sum},   {16'd0, es});
    chk({tag, "_cout"},  {31'd0, bus.out_cout},  {31'd0, ec});
    chk({tag, "_ovf"},   {31'd0, bus.out_ovf},   {31'd0, eo});
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    start_op(a, b, cin, sub);
    wait_result(lat);
    chk({tag, "_lat"}, lat, 32'd4);
    check_result(tag, es, ec, eo);
    @(posedge clk); #1;
    chk({tag, "_vclr"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_rdy"},  {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    int   lat;
    int   prev_acc;
    int   acc;
    vec_t tv[4];

    n_vec = 0;
    n_err = 0;
    scramble     = 1'b1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_cin   = 1'b0;
    bus.in_sub   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_sum",   {16'd0, bus.out_sum},   32'd0);
    chk("rst_out_cout",  {31'd0, bus.out_cout},  32'd0);
    chk("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_post", {31'd0, bus.in_ready}, 32'd1);

    // Basic add and carry propagation
    do_op("add1234",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("addffff",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add7fff",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("addcin",   16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Subtract; carry-in set at accept must be ignored
    do_op("sub5m7",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub8000",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-pressure: result held, in_valid pulses ignored
    bus.out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result(lat);
    chk("hold_lat", lat, 32'd4);
    check_result("hold0", 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_a     = 16'hAAAA;
      bus.in_b     = 16'h5555;
      @(posedge clk); #1;
      check_result("hold", 16'h3333, 1'b0, 1'b0);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("hold_rel_ready", {31'd0, bus.in_ready},  32'd1);

    // Asynchronous reset during RUN discards the operation
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_sum",   {16'd0, bus.out_sum},   32'd0);
    chk("arst_out_cout",  {31'd0, bus.out_cout},  32'd0);
    chk("arst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    #3;
    rst_n = 1'b1;
    chk("arst_rel_pre", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("arst_rel_post",  {31'd0, bus.in_ready},  32'd1);
    chk("arst_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    tv[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    tv[1] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    tv[2] = '{16'h9000, 16'h9000, 1'b0, 16'h2000, 1'b1, 1'b1};
    tv[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    scramble     = 1'b0;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    prev_acc     = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_a   = tv[i].a;
      bus.in_b   = tv[i].b;
      bus.in_sub = tv[i].sub;
      wait_ready();
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) chk("b2b_period", acc - prev_acc, 32'd6);
      prev_acc = acc;
      wait_result(lat);
      chk("b2b_lat", lat, 32'd4);
      check_result("b2b", tv[i].s, tv[i].c, tv[i].o);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
